// File: rtl/l2_mem_responder_if.sv
// rtl/l2_mem_responder_if.sv - L2 cache memory-port bundle between the L2 cache and the memory responder
interface l2_mem_responder_if #(
    parameter int OFFSET_WIDTH = 3
);
    localparam int LINE_W = 32 << OFFSET_WIDTH;

    logic [31:0]       addr_l2cache_mem_r;
    logic [31:0]       addr_l2cache_mem_w;
    logic [LINE_W-1:0] dout_l2cache_mem;
    logic [LINE_W-1:0] din_mem_l2cache;
    logic              l2cache_mem_req_r;
    logic              l2cache_mem_req_w;
    logic              l2cache_mem_rdy;
    logic              l2cache_mem_SUC;
    logic [3:0]        l2cache_mem_wstrb;
    logic [1:0]        l2cache_mem_size;
    logic              mem_l2cache_addrOK_r;
    logic              mem_l2cache_addrOK_w;
    logic              mem_l2cache_dataOK;

    modport master (
        output addr_l2cache_mem_r, addr_l2cache_mem_w, dout_l2cache_mem,
               l2cache_mem_req_r, l2cache_mem_req_w, l2cache_mem_rdy,
               l2cache_mem_SUC, l2cache_mem_wstrb, l2cache_mem_size,
        input  din_mem_l2cache, mem_l2cache_addrOK_r, mem_l2cache_addrOK_w,
               mem_l2cache_dataOK
    );

    modport slave (
        input  addr_l2cache_mem_r, addr_l2cache_mem_w, dout_l2cache_mem,
               l2cache_mem_req_r, l2cache_mem_req_w, l2cache_mem_rdy,
               l2cache_mem_SUC, l2cache_mem_wstrb, l2cache_mem_size,
        output din_mem_l2cache, mem_l2cache_addrOK_r, mem_l2cache_addrOK_w,
               mem_l2cache_dataOK
    );
endinterface

// File: rtl/l2_mem_responder.sv
// rtl/l2_mem_responder.sv - single-outstanding memory responder for the L2 cache memory port
module l2_mem_responder #(
    parameter int OFFSET_WIDTH   = 3,
    parameter int MEM_ADDR_WIDTH = 14,
    parameter int RD_LATENCY     = 4
) (
    input logic               clk,
    input logic               rst,
    l2_mem_responder_if.slave bus
);
    localparam int WORDS  = 1 << OFFSET_WIDTH;
    localparam int LINE_W = 32 * WORDS;
    localparam int DEPTH  = 1 << MEM_ADDR_WIDTH;
    localparam int BEAT_W = (OFFSET_WIDTH > 0) ? OFFSET_WIDTH : 1;
    localparam int LAT_W  = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0]          LAT_LAST  = LAT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);
    localparam logic [BEAT_W-1:0]         BEAT_LAST = BEAT_W'(WORDS - 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] LINE_MASK = ~MEM_ADDR_WIDTH'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, WAIT, XFER, RESP} state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [31:0]               mem [DEPTH];
    logic [MEM_ADDR_WIDTH-1:0] base_q;
    logic                      suc_q;
    logic                      write_q;
    logic [3:0]                wstrb_q;
    logic [LINE_W-1:0]         wdata_q;
    logic [LINE_W-1:0]         rdata_q;
    logic [BEAT_W-1:0]         beat;
    logic [LAT_W-1:0]          lat;

    logic                      accept_w;
    logic                      accept_r;
    logic                      last_beat;
    logic [31:0]               req_addr;
    logic [MEM_ADDR_WIDTH-1:0] req_idx;
    logic [MEM_ADDR_WIDTH-1:0] word_idx;
    logic [31:0]               wword;
    logic [3:0]                be;
    logic                      unused_bits;

    // Write has priority; a concurrent read simply stays pending.
    assign accept_w  = (state == IDLE) & bus.l2cache_mem_req_w & ~rst;
    assign accept_r  = (state == IDLE) & bus.l2cache_mem_req_r & ~bus.l2cache_mem_req_w & ~rst;
    assign req_addr  = bus.l2cache_mem_req_w ? bus.addr_l2cache_mem_w : bus.addr_l2cache_mem_r;
    assign req_idx   = req_addr[MEM_ADDR_WIDTH+1:2];
    assign last_beat = suc_q | (beat == BEAT_LAST);
    assign word_idx  = base_q + MEM_ADDR_WIDTH'(beat);
    assign wword     = wdata_q[{beat, 5'b0} +: 32];
    assign be        = suc_q ? wstrb_q : 4'hF;

    assign bus.mem_l2cache_addrOK_w = accept_w;
    assign bus.mem_l2cache_addrOK_r = accept_r;
    assign bus.mem_l2cache_dataOK   = (state == RESP) & bus.l2cache_mem_rdy & ~rst;
    assign bus.din_mem_l2cache      = rdata_q;

    assign unused_bits = ^{bus.l2cache_mem_size, req_addr[31:MEM_ADDR_WIDTH+2], req_addr[1:0]};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_w)      state_nxt = XFER;
                else if (accept_r) state_nxt = (RD_LATENCY == 0) ? XFER : WAIT;
            end
            WAIT:    if (lat == LAT_LAST)        state_nxt = XFER;
            XFER:    if (last_beat)              state_nxt = RESP;
            RESP:    if (bus.l2cache_mem_rdy)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            beat    <= '0;
            lat     <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept_w | accept_r) begin
                base_q  <= bus.l2cache_mem_SUC ? req_idx : (req_idx & LINE_MASK);
                suc_q   <= bus.l2cache_mem_SUC;
                wstrb_q <= bus.l2cache_mem_wstrb;
                wdata_q <= bus.dout_l2cache_mem;
                write_q <= accept_w;
                beat    <= '0;
                lat     <= '0;
            end
            if (state == WAIT) lat <= lat + 1'b1;
            if (state == XFER) begin
                beat <= beat + 1'b1;
                if (!write_q) begin
                    if (suc_q) rdata_q <= LINE_W'(mem[word_idx]);
                    else       rdata_q[{beat, 5'b0} +: 32] <= mem[word_idx];
                end
            end
        end
    end

    // Array is deliberately not reset so contents survive a mid-run reset.
    always_ff @(posedge clk) begin
        if (state == XFER && write_q && !rst) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[word_idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_l2_mem_responder.sv
// tb/tb_l2_mem_responder.sv - randomized self-checking bench for l2_mem_responder
module tb_l2_mem_responder;
    localparam int OW         = 3;
    localparam int MAW        = 14;
    localparam int RD_LATENCY = 4;
    localparam int WORDS      = 1 << OW;
    localparam int LW         = 32 * WORDS;
    localparam int DEPTH      = 1 << MAW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0]   ref_mem [DEPTH];
    logic [LW-1:0] line_a, line_b, line_c, rdata;
    logic [31:0]   addr;
    logic [3:0]    strb;
    bit            wr, suc;
    int            dly;

    l2_mem_responder_if #(.OFFSET_WIDTH(OW)) bus ();

    l2_mem_responder #(
        .OFFSET_WIDTH  (OW),
        .MEM_ADDR_WIDTH(MAW),
        .RD_LATENCY    (RD_LATENCY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & (DEPTH - 1));
    endfunction

    function automatic logic [LW-1:0] exp_line(input logic [31:0] a, input bit s);
        logic [LW-1:0] r;
        int base;
        r = '0;
        if (s) begin
            r[31:0] = ref_mem[widx(a)];
        end else begin
            base = widx(a) & ~(WORDS - 1);
            for (int i = 0; i < WORDS; i++) r[32*i +: 32] = ref_mem[base + i];
        end
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input bit s, input logic [LW-1:0] d, input logic [3:0] st);
        int base;
        if (s) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
        end else begin
            base = widx(a) & ~(WORDS - 1);
            for (int i = 0; i < WORDS; i++) ref_mem[base + i] = d[32*i +: 32];
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < WORDS; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Present a request in the current (idle) cycle and confirm it is taken immediately.
    task automatic start(input bit w, input bit s, input logic [31:0] a, input logic [LW-1:0] d,
                         input logic [3:0] st, input bit both);
        bus.addr_l2cache_mem_r = a;
        bus.addr_l2cache_mem_w = a;
        bus.dout_l2cache_mem   = d;
        bus.l2cache_mem_SUC    = s;
        bus.l2cache_mem_wstrb  = st;
        bus.l2cache_mem_size   = s ? 2'b10 : 2'b11;
        bus.l2cache_mem_req_w  = w;
        bus.l2cache_mem_req_r  = !w || both;
        #1;
        check("addrok_w", bus.mem_l2cache_addrOK_w, w);
        check("addrok_r", bus.mem_l2cache_addrOK_r, !w);
        if (w) model_write(a, s, d, st);
    endtask

    task automatic complete(input bit w, input bit s, input int rdy_delay, input bit hold_r,
                            input logic [LW-1:0] exp_din);
        int exp_lat;
        int hit;
        logic [LW-1:0] snap;
        exp_lat = (w ? 0 : RD_LATENCY) + (s ? 1 : WORDS) + 1;
        hit = 0;
        snap = '0;
        for (int k = 1; k <= exp_lat + rdy_delay + 8 && hit == 0; k++) begin
            @(negedge clk);
            bus.l2cache_mem_req_w = 1'b0;
            bus.l2cache_mem_req_r = hold_r;
            bus.l2cache_mem_rdy   = (k >= exp_lat + rdy_delay);
            #1;
            if (!w && k == exp_lat) snap = bus.din_mem_l2cache;
            if (!w && k > exp_lat && k <= exp_lat + rdy_delay) check("din_stable", bus.din_mem_l2cache, snap);
            if (hold_r) check("pending_rd_blocked", bus.mem_l2cache_addrOK_r, 0);
            if (bus.mem_l2cache_dataOK) hit = k;
        end
        check("dataok_cycle", hit, exp_lat + rdy_delay);
        if (!w) check("rd_data", bus.din_mem_l2cache, exp_din);
        @(negedge clk);
        bus.l2cache_mem_rdy   = 1'b1;
        bus.l2cache_mem_req_w = 1'b0;
        bus.l2cache_mem_req_r = hold_r;
        #1;
        check("dataok_pulse", bus.mem_l2cache_dataOK, 0);
        if (hold_r) check("held_rd_accept", bus.mem_l2cache_addrOK_r, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.addr_l2cache_mem_r = '0;
        bus.addr_l2cache_mem_w = '0;
        bus.dout_l2cache_mem   = '0;
        bus.l2cache_mem_req_r  = 1'b0;
        bus.l2cache_mem_req_w  = 1'b0;
        bus.l2cache_mem_rdy    = 1'b1;
        bus.l2cache_mem_SUC    = 1'b0;
        bus.l2cache_mem_wstrb  = '0;
        bus.l2cache_mem_size   = '0;

        // Reset: requests must be ignored and outputs held at zero.
        repeat (2) @(negedge clk);
        bus.l2cache_mem_req_w = 1'b1;
        bus.l2cache_mem_req_r = 1'b1;
        #1;
        check("rst_addrok_w", bus.mem_l2cache_addrOK_w, 0);
        check("rst_addrok_r", bus.mem_l2cache_addrOK_r, 0);
        check("rst_dataok", bus.mem_l2cache_dataOK, 0);
        check("rst_din", bus.din_mem_l2cache, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.l2cache_mem_req_w = 1'b0;
        bus.l2cache_mem_req_r = 1'b0;

        // Line write / line read round trip.
        for (int i = 0; i < WORDS; i++) line_a[32*i +: 32] = 32'h1111_1111 * (i + 1);
        start(1, 0, 32'h0000_1000, line_a, 4'h0, 0);
        complete(1, 0, 0, 0, '0);
        start(0, 0, 32'h0000_1000, '0, 4'h0, 0);
        complete(0, 0, 0, 0, exp_line(32'h0000_1000, 0));
        check("line_roundtrip", bus.din_mem_l2cache, line_a);

        // Uncached byte-masked write then uncached read.
        start(1, 1, 32'h0000_1004, LW'(32'hAABB_CCDD), 4'b0011, 0);
        complete(1, 1, 0, 0, '0);
        start(0, 1, 32'h0000_1004, '0, 4'h0, 0);
        complete(0, 1, 0, 0, exp_line(32'h0000_1004, 1));
        check("suc_merge", bus.din_mem_l2cache, LW'(32'h2222_CCDD));

        // Simultaneous requests: write first, read held and accepted after dataOK.
        line_b = rand_line();
        start(1, 0, 32'h0000_1020, line_b, 4'h0, 1);
        complete(1, 0, 0, 1, '0);
        complete(0, 0, 0, 0, line_b);

        // Back-pressure in RESP.
        start(0, 0, 32'h0000_1000, '0, 4'h0, 0);
        complete(0, 0, 3, 0, exp_line(32'h0000_1000, 0));

        // Aliasing modulo the array size.
        line_c = rand_line();
        start(1, 0, 32'h0001_0000, line_c, 4'h0, 0);
        complete(1, 0, 0, 0, '0);
        start(0, 0, 32'h0000_0000, '0, 4'h0, 0);
        complete(0, 0, 0, 0, line_c);

        // Reset during a read transfer.
        start(0, 0, 32'h0000_1000, '0, 4'h0, 0);
        for (int k = 1; k <= RD_LATENCY + 2; k++) begin
            @(negedge clk);
            bus.l2cache_mem_req_r = 1'b0;
            #1;
            check("mid_no_dataok", bus.mem_l2cache_dataOK, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.l2cache_mem_req_r = 1'b1;
        #1;
        check("rst_mid_addrok_r", bus.mem_l2cache_addrOK_r, 0);
        @(negedge clk);
        #1;
        check("rst_mid_din", bus.din_mem_l2cache, 0);
        check("rst_mid_dataok", bus.mem_l2cache_dataOK, 0);
        check("rst_mid_addrok_r2", bus.mem_l2cache_addrOK_r, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.l2cache_mem_req_r = 1'b0;
        start(1, 1, 32'h0000_1008, LW'($urandom), 4'b1111, 0);
        complete(1, 1, 0, 0, '0);

        // Fill the region used by the random phase (line 0 already written above).
        for (int l = 1; l < 4; l++) begin
            start(1, 0, 32'(l * 32), rand_line(), 4'h0, 0);
            complete(1, 0, 0, 0, '0);
        end

        for (int n = 0; n < 40; n++) begin
            wr   = 1'($urandom_range(0, 1));
            suc  = 1'($urandom_range(0, 1));
            addr = ($urandom & 32'hFFFF_0000) | (32'($urandom_range(0, 31)) << 2);
            line_a = rand_line();
            strb = 4'($urandom);
            dly  = $urandom_range(0, 2);
            start(wr, suc, addr, line_a, strb, 0);
            rdata = exp_line(addr, suc);
            complete(wr, suc, dly, 0, rdata);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/l2_mem_responder.md
# l2_mem_responder

Memory-side responder for the L2 cache's memory port: it accepts line or uncached word read/write requests from the L2 cache, services them from an internal word-addressed memory array, and returns read lines with a data-OK handshake. It sits below the L2 cache in simulation and FPGA bring-up builds in place of the external bus bridge. It handles one transaction at a time, with a programmable read latency.

## Interface
- `OFFSET_WIDTH`, default 3: log2 of words per line; a line is 32·2^OFFSET_WIDTH bits.
- `MEM_ADDR_WIDTH`, default 14: log2 of array depth in 32-bit words.
- `RD_LATENCY`, default 4: wait cycles inserted before a read transfer; 0 is legal.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `addr_l2cache_mem_r` in 32: read byte address.
- `addr_l2cache_mem_w` in 32: write byte address.
- `dout_l2cache_mem` in 32·2^OFFSET_WIDTH: write data; word i is at bits [32i+31:32i].
- `din_mem_l2cache` out 32·2^OFFSET_WIDTH: read data.
- `l2cache_mem_req_r` in 1: read request, held until `mem_l2cache_addrOK_r`.
- `l2cache_mem_req_w` in 1: write request, held until `mem_l2cache_addrOK_w`.
- `l2cache_mem_rdy` in 1: L2 can take a response.
- `l2cache_mem_SUC` in 1: 1 = uncached single-word access, 0 = full line.
- `l2cache_mem_wstrb` in 4: byte enables for uncached writes.
- `l2cache_mem_size` in 2: access size; informational only, not decoded.
- `mem_l2cache_addrOK_r` out 1: read request accepted.
- `mem_l2cache_addrOK_w` out 1: write request accepted.
- `mem_l2cache_dataOK` out 1: one-cycle completion pulse, used for both reads and writes.

## Operation
- States: IDLE, WAIT, XFER, RESP.
- Request attributes are captured on acceptance: address, SUC, wstrb, write data, and direction.
- IDLE acceptance:
  - `mem_l2cache_addrOK_w = IDLE & req_w & ~rst`.
  - `mem_l2cache_addrOK_r = IDLE & req_r & ~req_w & ~rst`.
  - Write wins when both requests are high; the read stays pending and is accepted in a later IDLE cycle.
- Beats: 2^OFFSET_WIDTH for a line, 1 for SUC.
- Word index = addr[MEM_ADDR_WIDTH+1:2]. For a line access the low OFFSET_WIDTH bits are cleared and the beat counter is added. Higher address bits are ignored, so addresses alias modulo the array size.
- Read path:
  - Accept → WAIT for RD_LATENCY cycles, or straight to XFER when RD_LATENCY = 0.
  - XFER reads one word per cycle into lane = beat counter of the response register.
  - SUC read puts the word in lane 0 and zeroes all other lanes.
- Write path:
  - Accept → XFER, writing one word per cycle from the captured data lanes.
  - Line writes write all bytes.
  - SUC writes write lane 0 to the addressed word, byte-masked by wstrb; wstrb = 0 leaves memory unchanged but the write still completes.
- Completion:
  - After the last beat the FSM goes to RESP.
  - `mem_l2cache_dataOK = (state == RESP) & l2cache_mem_rdy`.
  - The FSM leaves RESP for IDLE on the cycle dataOK is high.
- `din_mem_l2cache`:
  - Holds its value from the last read beat until the next read's first beat.
  - Is stable throughout RESP.
  - Is not modified by writes.
- Reset:
  - Forces IDLE and clears the beat and latency counters.
  - Clears `din_mem_l2cache` to 0; every other output is 0 during and after reset.
  - The memory array is not cleared.
  - Reset mid-transaction abandons the transaction. A partially written line keeps the beats already written.

## Timing
- Acceptance cycle T: addrOK is high combinationally and attributes are registered at the end of T.
- Read:
  - WAIT occupies T+1 … T+RD_LATENCY.
  - XFER occupies the next `beats` cycles.
  - Earliest dataOK is at T+RD_LATENCY+beats+1.
- Write: XFER occupies T+1 … T+beats; earliest dataOK is at T+beats+1.
- Memory read-after-write: a read accepted after a write's dataOK observes that write.
- If rdy is low in RESP, dataOK waits. It asserts on the first rdy-high cycle, for exactly one cycle.
- Earliest next acceptance is the cycle after dataOK. There is no back-to-back acceptance in the dataOK cycle.
- Throughput is one outstanding transaction.

## Test plan
- Line write/read round trip (RD_LATENCY = 4):
  - Write 0x0000_1000, word i = 0x1111_1111·(i+1), accepted at T → dataOK at T+9.
  - Read 0x0000_1000 accepted at U → dataOK at U+13; `din` matches all 8 words.
- Uncached byte-masked write:
  - Pre-line word at 0x1004 = 0x2222_2222.
  - SUC write 0xAABB_CCDD with wstrb = 0011.
  - SUC read 0x1004 → lane 0 = 0x2222_CCDD, other lanes 0, dataOK at accept+6.
- Simultaneous requests: req_r and req_w high together in IDLE → only addrOK_w; addrOK_r on the cycle after the write's dataOK; the read returns the written data.
- Back-pressure: rdy held low for 3 cycles in RESP → no dataOK and `din` stable; dataOK is a single-cycle pulse on the first rdy-high cycle.
- Aliasing: line write to 0x0001_0000 (MEM_ADDR_WIDTH = 14), then line read of 0x0000_0000 → identical data.
- Mid-read reset: assert rst during XFER → next cycle all outputs 0 and state IDLE; a new request is accepted the cycle after rst deasserts.
